// File: rtl/fp_normalizer_pkg.sv
// Shared floating-point constants and the state/decision encodings for the normalize stage.
package fp_normalizer_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = 127;
    localparam int SHIFT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_DONE
    } state_t;

    // Outcome of one NORM-cycle inspection of the working mantissa/exponent.
    typedef enum logic [2:0] {
        DEC_ZERO,
        DEC_INF,
        DEC_CARRY,
        DEC_NORM,
        DEC_UFLOW,
        DEC_SHIFT
    } decision_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Handshake bus of the normalize stage: operand side (in_*) and result side (out_*).
interface fp_normalizer_if
    import fp_normalizer_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic [EXP_W-1:0]         in_exp;
    logic [MAN_W+1:0]         in_man;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+MAN_W:0]     out_result;
    logic [SHIFT_W-1:0]       out_shift;
    logic                     out_zero;
    logic                     out_overflow;
    logic                     out_underflow;

    // Environment: supplies operands and consumes results.
    modport master (
        output in_valid, in_sign, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_result, out_shift,
               out_zero, out_overflow, out_underflow
    );

    // Normalizer: accepts operands and presents results.
    modport slave (
        input  in_valid, in_sign, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_result, out_shift,
               out_zero, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_normalizer.sv
// Post-add normalize stage: restores the hidden-one position of a mantissa sum
// (1-bit right shift on carry, or 1-bit/cycle left shifts) and packs an IEEE-754 result.
module fp_normalizer
    import fp_normalizer_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_normalizer_if.slave       bus
);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_LIM  = EXP_ONES - EXP_W'(1);

    state_t               state;
    state_t               next_state;
    decision_t            dec;

    logic                 sign_q;
    logic [EXP_W-1:0]     exp_q;
    logic [MAN_W+1:0]     man_q;
    logic [SHIFT_W-1:0]   shift_q;

    logic [EXP_W+MAN_W:0] result_q;
    logic [SHIFT_W-1:0]   shift_out_q;
    logic                 zero_q;
    logic                 overflow_q;
    logic                 underflow_q;

    assign bus.in_ready      = (state == ST_IDLE);
    assign bus.out_valid     = (state == ST_DONE);
    assign bus.out_result    = result_q;
    assign bus.out_shift     = shift_out_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_overflow  = overflow_q;
    assign bus.out_underflow = underflow_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority decision on the working value and next-state selection.
    always_comb begin
        next_state = state;
        dec        = DEC_SHIFT;

        if (man_q == '0) begin
            dec = DEC_ZERO;
        end else if (exp_q == EXP_ONES) begin
            dec = DEC_INF;
        end else if (man_q[MAN_W+1]) begin
            dec = (exp_q >= EXP_LIM) ? DEC_INF : DEC_CARRY;
        end else if (man_q[MAN_W]) begin
            dec = DEC_NORM;
        end else if (exp_q <= EXP_W'(1)) begin
            dec = DEC_UFLOW;
        end

        case (state)
            ST_IDLE: if (bus.in_valid)      next_state = ST_NORM;
            ST_NORM: if (dec != DEC_SHIFT)  next_state = ST_DONE;
            ST_DONE: if (bus.out_ready)     next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
    end

    // Working registers, left-shift loop, and result packing on the way into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            shift_q     <= '0;
            result_q    <= '0;
            shift_out_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_q  <= bus.in_sign;
                        exp_q   <= bus.in_exp;
                        man_q   <= bus.in_man;
                        shift_q <= '0;
                    end
                end
                ST_NORM: begin
                    if (dec == DEC_SHIFT) begin
                        man_q   <= man_q << 1;
                        exp_q   <= exp_q - EXP_W'(1);
                        shift_q <= shift_q + SHIFT_W'(1);
                    end else begin
                        shift_out_q <= shift_q;
                        zero_q      <= (dec == DEC_ZERO);
                        overflow_q  <= (dec == DEC_INF);
                        underflow_q <= (dec == DEC_UFLOW);
                        case (dec)
                            DEC_INF:   result_q <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                            // Right shift by one: fraction is man[MAN_W:1], LSB dropped.
                            DEC_CARRY: result_q <= {sign_q, exp_q + EXP_W'(1), man_q[MAN_W:1]};
                            DEC_NORM:  result_q <= {sign_q, exp_q, man_q[MAN_W-1:0]};
                            default:   result_q <= {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer.
module tb_fp_normalizer;
    import fp_normalizer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_normalizer_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_normalizer #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [2:0] flags();
        return {bus.out_zero, bus.out_overflow, bus.out_underflow};
    endfunction

    // Present one operand and wait (bounded) for out_valid; lat counts edges after acceptance.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_man   = m;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", bus.out_result); end
        total++; if (bus.out_shift !== 5'd0 || flags() !== 3'b000) begin
            bad++; $display("FAIL reset_shift_flags got=%0d/%b exp=0/000", bus.out_shift, flags());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normalized();
        int lat;
        run_op(1'b0, 8'h80, 25'h0800000, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL t1_latency got=%0d exp=1", lat); end
        total++; if (bus.out_result !== 32'h40000000) begin bad++; $display("FAIL t1_result got=%h exp=40000000", bus.out_result); end
        total++; if (bus.out_shift !== 5'd0) begin bad++; $display("FAIL t1_shift got=%0d exp=0", bus.out_shift); end
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL t1_flags got=%b exp=000", flags()); end
        release_op();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL t1_release got=v%b/r%b exp=v0/r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_carry();
        int lat;
        run_op(1'b0, 8'h7F, 25'h1800000, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL t2_latency got=%0d exp=1", lat); end
        total++; if (bus.out_result !== 32'h40400000) begin bad++; $display("FAIL t2_result got=%h exp=40400000", bus.out_result); end
        total++; if (flags() !== 3'b000 || bus.out_shift !== 5'd0) begin
            bad++; $display("FAIL t2_flags got=%b/%0d exp=000/0", flags(), bus.out_shift);
        end
        release_op();
        // Carry on odd mantissa: LSB is truncated.
        run_op(1'b1, 8'h80, 25'h1000003, lat);
        total++; if (bus.out_result !== 32'hC0800001) begin bad++; $display("FAIL t2_trunc got=%h exp=c0800001", bus.out_result); end
        release_op();
    endtask

    task automatic test_long_shift();
        int lat;
        run_op(1'b0, 8'h85, 25'h0000001, lat);
        total++; if (lat !== 24) begin bad++; $display("FAIL t3_latency got=%0d exp=24", lat); end
        total++; if (bus.out_result !== 32'h37000000) begin bad++; $display("FAIL t3_result got=%h exp=37000000", bus.out_result); end
        total++; if (bus.out_shift !== 5'd23) begin bad++; $display("FAIL t3_shift got=%0d exp=23", bus.out_shift); end
        total++; if (flags() !== 3'b000) begin bad++; $display("FAIL t3_flags got=%b exp=000", flags()); end
        release_op();
    endtask

    task automatic test_zero_overflow();
        int lat;
        run_op(1'b1, 8'h90, 25'h0, lat);
        total++; if (bus.out_result !== 32'h80000000) begin bad++; $display("FAIL t4_zero_result got=%h exp=80000000", bus.out_result); end
        total++; if (flags() !== 3'b100) begin bad++; $display("FAIL t4_zero_flags got=%b exp=100", flags()); end
        release_op();
        run_op(1'b0, 8'hFE, 25'h1000000, lat);
        total++; if (bus.out_result !== 32'h7F800000) begin bad++; $display("FAIL t4_carry_inf got=%h exp=7f800000", bus.out_result); end
        total++; if (flags() !== 3'b010) begin bad++; $display("FAIL t4_carry_inf_flags got=%b exp=010", flags()); end
        release_op();
        run_op(1'b1, 8'hFF, 25'h0800000, lat);
        total++; if (bus.out_result !== 32'hFF800000 || flags() !== 3'b010) begin
            bad++; $display("FAIL t4_exp_ones got=%h/%b exp=ff800000/010", bus.out_result, flags());
        end
        release_op();
        // Carry just below the limit still renormalizes to the largest finite exponent.
        run_op(1'b0, 8'hFD, 25'h1000000, lat);
        total++; if (bus.out_result !== 32'h7F000000 || flags() !== 3'b000) begin
            bad++; $display("FAIL t4_carry_fd got=%h/%b exp=7f000000/000", bus.out_result, flags());
        end
        release_op();
    endtask

    task automatic test_underflow();
        int lat;
        run_op(1'b0, 8'h02, 25'h0200000, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL t5_latency got=%0d exp=2", lat); end
        total++; if (bus.out_result !== 32'h00000000) begin bad++; $display("FAIL t5_result got=%h exp=00000000", bus.out_result); end
        total++; if (flags() !== 3'b001 || bus.out_shift !== 5'd1) begin
            bad++; $display("FAIL t5_flags got=%b/%0d exp=001/1", flags(), bus.out_shift);
        end
        release_op();
    endtask

    task automatic test_hold();
        int lat;
        run_op(1'b0, 8'h7F, 25'h1800000, lat);
        bus.in_sign  = 1'b1;
        bus.in_exp   = 8'h10;
        bus.in_man   = 25'h0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                         bus.out_result !== 32'h40400000 || flags() !== 3'b000) begin
                bad++; $display("FAIL t6_hold cyc=%0d got=v%b r%b %h %b exp=v1 r0 40400000 000",
                                i, bus.out_valid, bus.in_ready, bus.out_result, flags());
            end
        end
        bus.in_valid = 1'b0;
        release_op();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL t6_release got=v%b/r%b exp=v0/r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_norm();
        int lat;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'h85;
        bus.in_man   = 25'h0000001;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t6_mid_norm got=r%b/v%b exp=r0/v0", bus.in_ready, bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0) begin
            bad++; $display("FAIL t6_async_reset got=v%b r%b %h exp=v0 r1 00000000",
                            bus.out_valid, bus.in_ready, bus.out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 8'h80, 25'h0800000, lat);
        total++; if (lat !== 1 || bus.out_result !== 32'h40000000 || bus.out_shift !== 5'd0) begin
            bad++; $display("FAIL t6_after_reset got=lat%0d %h sh%0d exp=lat1 40000000 sh0",
                            lat, bus.out_result, bus.out_shift);
        end
        release_op();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_man    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_normalized();
        test_carry();
        test_long_shift();
        test_zero_overflow();
        test_underflow();
        test_hold();
        test_reset_mid_norm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
